gpo_access_arbiter: RTL and testbench

- Sequences single register accesses from two independent requesters (e.g. BMC I2C slave and host-side bridge) into one port of the GPO register bank.
- Drives the bank's chip-select, one-hot 16-bit offset select, read/write and write-data signals.
- Captures the bank's registered read data and returns it with a one-cycle ACK pulse.
- Round-robin fair; one outstanding access at a time.

---
 rtl/gpo_access_arbiter_pkg.sv | 21 ++
 rtl/gpo_access_arbiter_rr.sv | 14 +
 rtl/gpo_access_arbiter.sv | 152 +++++++++++++++
 tb/tb_gpo_access_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpo_access_arbiter_pkg.sv
// Shared widths, FSM encoding and helpers for the GPO register-bank access arbiter.
package gpo_access_arbiter_pkg;
  localparam int         GPO_AW           = 4;
  localparam int         GPO_DW           = 8;
  localparam int         GPO_NSEL         = 1 << GPO_AW;
  localparam logic [7:0] GPO_LOCK_TMO_DEF = 8'd64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } arb_state_t;

  function automatic logic [GPO_NSEL-1:0] addr_decode(input logic [GPO_AW-1:0] addr);
    logic [GPO_NSEL-1:0] d;
    d       = '0;
    d[addr] = 1'b1;
    return d;
  endfunction
endpackage

// File: rtl/gpo_access_arbiter_rr.sv
// Two-way round-robin picker: pointer breaks ties, a lone eligible request always wins.
module gpo_arb_rr (
  input  logic [1:0] req_i,
  input  logic [1:0] elig_i,
  input  logic       ptr_i,
  output logic       gnt_idx_o,
  output logic       gnt_vld_o
);
  logic [1:0] cand;

  assign cand      = req_i & elig_i;
  assign gnt_vld_o = |cand;
  assign gnt_idx_o = (cand == 2'b11) ? ptr_i : cand[1];
endmodule

// File: rtl/gpo_access_arbiter.sv
// Serialises single accesses from two requesters onto one GPO bank port (IDLE->ISSUE->CAPTURE->DONE).
// Define GPO_ARB_LOCK_EN to add LOCK0/LOCK1 for atomic read-modify-write with an idle timeout.
module gpo_access_arbiter
  import gpo_access_arbiter_pkg::*;
#(
  parameter logic       INIT_PRIO = 1'b0,
  parameter logic [7:0] LOCK_TMO  = GPO_LOCK_TMO_DEF
) (
  input  logic                SYSCLK,
  input  logic                RESET,
  input  logic                REQ0,
  input  logic                REQ1,
  input  logic [GPO_AW-1:0]   ADDR0,
  input  logic [GPO_AW-1:0]   ADDR1,
  input  logic                WR0,
  input  logic                WR1,
  input  logic [GPO_DW-1:0]   WDATA0,
  input  logic [GPO_DW-1:0]   WDATA1,
`ifdef GPO_ARB_LOCK_EN
  input  logic                LOCK0,
  input  logic                LOCK1,
`endif
  output logic                ACK0,
  output logic                ACK1,
  output logic [GPO_DW-1:0]   RDATA0,
  output logic [GPO_DW-1:0]   RDATA1,
  output logic                PORT_CS,
  output logic [GPO_NSEL-1:0] OFFSET_SEL,
  output logic                RD_WR,
  output logic [GPO_DW-1:0]   DIN,
  input  logic [GPO_DW-1:0]   DOUT,
  output logic                BUSY
);
  arb_state_t          state_q;
  logic                ptr_q, gnt_q, wr_q;
  logic [GPO_DW-1:0]   wdata_q, din_q, rdata0_q, rdata1_q;
  logic                cs_q, rdwr_q;
  logic [GPO_NSEL-1:0] sel_q;
  logic [1:0]          ack_q;

  logic [1:0]          elig;
  logic                gnt_idx, gnt_vld;
  logic [GPO_AW-1:0]   req_addr;
  logic                req_wr;
  logic [GPO_DW-1:0]   req_wdata;

  gpo_arb_rr u_rr (
    .req_i     ({REQ1, REQ0}),
    .elig_i    (elig),
    .ptr_i     (ptr_q),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  assign req_addr  = gnt_idx ? ADDR1  : ADDR0;
  assign req_wr    = gnt_idx ? WR1    : WR0;
  assign req_wdata = gnt_idx ? WDATA1 : WDATA0;

`ifdef GPO_ARB_LOCK_EN
  logic       lock_q, lock_own_q, lock_hold, own_req;
  logic [7:0] lock_cnt_q;

  // Lock only restricts eligibility while the holder keeps its LOCK asserted.
  assign lock_hold = lock_q & (lock_own_q ? LOCK1 : LOCK0);
  assign own_req   = lock_own_q ? REQ1 : REQ0;
  assign elig      = !lock_hold ? 2'b11 : (lock_own_q ? 2'b10 : 2'b01);

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      lock_q     <= 1'b0;
      lock_own_q <= 1'b0;
      lock_cnt_q <= '0;
    end else if (state_q == ST_DONE) begin
      if (gnt_q ? LOCK1 : LOCK0) begin
        lock_q     <= 1'b1;
        lock_own_q <= gnt_q;
      end
      lock_cnt_q <= '0;
    end else if (state_q == ST_IDLE && lock_q) begin
      if (!lock_hold || (!own_req && (lock_cnt_q + 8'd1 >= LOCK_TMO))) begin
        lock_q     <= 1'b0;
        lock_cnt_q <= '0;
      end else if (own_req) begin
        lock_cnt_q <= '0;
      end else begin
        lock_cnt_q <= lock_cnt_q + 8'd1;
      end
    end
  end
`else
  logic unused_lock_tmo;
  assign unused_lock_tmo = ^LOCK_TMO;
  assign elig            = 2'b11;
`endif

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      ptr_q    <= INIT_PRIO;
      gnt_q    <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      cs_q     <= 1'b0;
      sel_q    <= '0;
      rdwr_q   <= 1'b0;
      din_q    <= '0;
      ack_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      cs_q   <= 1'b0;
      sel_q  <= '0;
      rdwr_q <= 1'b0;
      din_q  <= '0;
      ack_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld) begin
            state_q <= ST_ISSUE;
            gnt_q   <= gnt_idx;
            ptr_q   <= ~gnt_idx;
            wr_q    <= req_wr;
            wdata_q <= req_wdata;
            // Bank strobes are loaded at grant so they are live for exactly the ISSUE cycle.
            cs_q    <= 1'b1;
            sel_q   <= addr_decode(req_addr);
            rdwr_q  <= ~req_wr;
            din_q   <= req_wdata;
          end
        end
        ST_ISSUE: state_q <= ST_CAPTURE;
        ST_CAPTURE: begin
          state_q      <= ST_DONE;
          ack_q[gnt_q] <= 1'b1;
          if (gnt_q) rdata1_q <= wr_q ? wdata_q : DOUT;
          else       rdata0_q <= wr_q ? wdata_q : DOUT;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign PORT_CS    = cs_q;
  assign OFFSET_SEL = sel_q;
  assign RD_WR      = rdwr_q;
  assign DIN        = din_q;
  assign ACK0       = ack_q[0];
  assign ACK1       = ack_q[1];
  assign RDATA0     = rdata0_q;
  assign RDATA1     = rdata1_q;
  assign BUSY       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_gpo_access_arbiter.sv
// Bench for gpo_access_arbiter: directed vectors, multi-cycle corner sequences and a random run
// against a transaction-level model (one access per 4 cycles, round-robin tie-break).
module tb_gpo_access_arbiter;
  logic        SYSCLK = 1'b0;
  logic        RESET  = 1'b1;
  logic        REQ0 = 1'b0, REQ1 = 1'b0, WR0 = 1'b0, WR1 = 1'b0;
  logic [3:0]  ADDR0 = '0, ADDR1 = '0;
  logic [7:0]  WDATA0 = '0, WDATA1 = '0;
`ifdef GPO_ARB_LOCK_EN
  logic        LOCK0 = 1'b0, LOCK1 = 1'b0;
`endif
  logic        ACK0, ACK1, PORT_CS, RD_WR, BUSY;
  logic [7:0]  RDATA0, RDATA1, DIN, DOUT;
  logic [15:0] OFFSET_SEL;

  always #5 SYSCLK = ~SYSCLK;

  gpo_access_arbiter #(.INIT_PRIO(1'b0), .LOCK_TMO(8'd4)) dut (
    .SYSCLK(SYSCLK), .RESET(RESET),
    .REQ0(REQ0), .REQ1(REQ1), .ADDR0(ADDR0), .ADDR1(ADDR1),
    .WR0(WR0), .WR1(WR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
`ifdef GPO_ARB_LOCK_EN
    .LOCK0(LOCK0), .LOCK1(LOCK1),
`endif
    .ACK0(ACK0), .ACK1(ACK1), .RDATA0(RDATA0), .RDATA1(RDATA1),
    .PORT_CS(PORT_CS), .OFFSET_SEL(OFFSET_SEL), .RD_WR(RD_WR), .DIN(DIN),
    .DOUT(DOUT), .BUSY(BUSY)
  );

  // Bank model: registered read one cycle after chip-select, random garbage otherwise.
  logic [7:0] bank_mem [16];
  function automatic int oh_idx(input logic [15:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 16; i++) if (oh[i]) r = i;
    return r;
  endfunction
  always @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 16; i++) bank_mem[i] <= 8'(i * 17);
      DOUT <= 8'h00;
    end else begin
      if (PORT_CS && !RD_WR) bank_mem[oh_idx(OFFSET_SEL)] <= DIN;
      DOUT <= (PORT_CS && RD_WR) ? bank_mem[oh_idx(OFFSET_SEL)] : 8'($urandom);
    end
  end

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
    cyc++;
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within cycle budget (cycle %0d)", nm, cyc);
  endtask

  task automatic wait_cs(input string nm, input int lim);
    bit ok;
    ok = 0;
    for (int t = 0; t < lim && !ok; t++) begin
      tick();
      if (PORT_CS) ok = 1;
    end
    if (!ok) timeout(nm);
  endtask

  task automatic wait_ack(input string nm, input int lim);
    bit ok;
    ok = 0;
    for (int t = 0; t < lim && !ok; t++) begin
      tick();
      if (ACK0 || ACK1) ok = 1;
    end
    if (!ok) timeout(nm);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    REQ0 = 0; REQ1 = 0; WR0 = 0; WR1 = 0; ADDR0 = 0; ADDR1 = 0; WDATA0 = 0; WDATA1 = 0;
`ifdef GPO_ARB_LOCK_EN
    LOCK0 = 0; LOCK1 = 0;
`endif
    tick();
    tick();
    chk("reset_ctl", {PORT_CS, ACK0, ACK1, RD_WR, BUSY, DIN, OFFSET_SEL}, 32'h0);
    chk("reset_rdata", {RDATA0, RDATA1}, 32'h0);
    RESET = 1'b0;
  endtask

  typedef struct {
    logic r0, r1; logic [3:0] a0, a1; logic w0, w1; logic [7:0] d0, d1;
    logic who; logic [15:0] off; logic rdwr; logic [7:0] din; logic [7:0] rdata;
  } vec_t;
  vec_t vt [8];

  int         gcyc, acyc, cs_n, t0, n_ack, last, cnt;
  logic [3:0] cont_ord;
  // Random-run model state.
  logic       m_ptr, g_who, g_wr, pend0, pend1, e_cs, e_ack0, e_ack1;
  int         g_edge;
  logic [3:0] g_addr;
  logic [7:0] g_wd, g_rd;
  logic [7:0] exp_mem [16];
  logic [7:0] exp_rd [2];
  logic [15:0] one16;

  initial begin
    vt[0] = '{1'b1, 1'b0, 4'h5, 4'h0, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 16'h0020, 1'b0, 8'hA5, 8'hA5};
    vt[1] = '{1'b0, 1'b1, 4'h0, 4'h5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 16'h0020, 1'b1, 8'h00, 8'hA5};
    vt[2] = '{1'b1, 1'b1, 4'h0, 4'hF, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b0, 16'h0001, 1'b0, 8'h3C, 8'h3C};
    vt[3] = '{1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 1'b1, 8'h00, 8'h77, 1'b1, 16'h8000, 1'b0, 8'h77, 8'h77};
    vt[4] = '{1'b1, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 16'h0001, 1'b1, 8'h00, 8'h3C};
    vt[5] = '{1'b1, 1'b0, 4'h9, 4'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 16'h0200, 1'b1, 8'h00, 8'h99};
    vt[6] = '{1'b0, 1'b1, 4'h0, 4'h3, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 16'h0008, 1'b1, 8'h00, 8'h33};
    vt[7] = '{1'b1, 1'b1, 4'h3, 4'h7, 1'b0, 1'b1, 8'h00, 8'hE1, 1'b0, 16'h0008, 1'b1, 8'h00, 8'h33};
    one16 = 16'h0001;

    do_reset();
    for (int k = 0; k < 8; k++) begin
      REQ0 = vt[k].r0; REQ1 = vt[k].r1; ADDR0 = vt[k].a0; ADDR1 = vt[k].a1;
      WR0 = vt[k].w0; WR1 = vt[k].w1; WDATA0 = vt[k].d0; WDATA1 = vt[k].d1;
      gcyc = -1; acyc = -1; cs_n = 0; t0 = cyc;
      for (int t = 0; t < 12 && acyc < 0; t++) begin
        tick();
        if (PORT_CS) begin
          cs_n++; gcyc = cyc;
          chk("vec_grant_lat", cyc - t0, 1);
          chk("vec_offset", OFFSET_SEL, vt[k].off);
          chk("vec_rd_wr", RD_WR, vt[k].rdwr);
          chk("vec_din", DIN, vt[k].din);
        end
        if (ACK0 || ACK1) begin
          acyc = cyc;
          chk("vec_ack_who", {ACK1, ACK0}, vt[k].who ? 2'b10 : 2'b01);
          chk("vec_rdata", vt[k].who ? RDATA1 : RDATA0, vt[k].rdata);
          chk("vec_ack_lat", acyc - gcyc, 2);
        end
      end
      if (acyc < 0) timeout("vec_ack");
      chk("vec_cs_cycles", cs_n, 1);
      REQ0 = 0; REQ1 = 0;
      tick();
      chk("vec_post_ack", {ACK0, ACK1, BUSY, PORT_CS}, 0);
      tick();
      chk("vec_idle", {PORT_CS, BUSY}, 0);
    end

    // Contention from reset: both held, grants must alternate 0,1,0,1 every 4 cycles.
    do_reset();
    REQ0 = 1; REQ1 = 1; ADDR0 = 4'h1; ADDR1 = 4'h2; WR0 = 0; WR1 = 0;
    cont_ord = 4'b1010; n_ack = 0; last = 0; t0 = cyc;
    for (int t = 0; t < 24 && n_ack < 4; t++) begin
      tick();
      chk("cont_overlap", ACK0 & ACK1, 0);
      if (ACK0 || ACK1) begin
        chk("cont_order", ACK1, cont_ord[n_ack]);
        chk("cont_rdata", ACK1 ? RDATA1 : RDATA0, ACK1 ? 8'h22 : 8'h11);
        if (n_ack > 0) chk("cont_spacing", cyc - last, 4);
        else           chk("cont_first_ack", cyc - t0, 3);
        last = cyc; n_ack++;
      end
    end
    chk("cont_count", n_ack, 4);
    REQ0 = 0; REQ1 = 0;
    tick(); tick();

    // Reset asserted during CAPTURE.
    REQ0 = 1; ADDR0 = 4'h6; WR0 = 1; WDATA0 = 8'h5A;
    wait_cs("rstmid_cs", 6);
    tick();
    chk("rstmid_busy_pre", BUSY, 1);
    RESET = 1'b1;
    #1;
    chk("rstmid_outs", {PORT_CS, ACK0, BUSY}, 0);
    chk("rstmid_rdata0", RDATA0, 0);
    REQ0 = 0;
    tick();
    RESET = 1'b0;
    cnt = 0;
    for (int t = 0; t < 8; t++) begin tick(); if (ACK0 || ACK1 || PORT_CS) cnt++; end
    chk("rstmid_no_ack", cnt, 0);
    REQ0 = 1; WR0 = 0;
    wait_ack("rstmid_rereq", 8);
    chk("rstmid_rereq_rdata", {ACK1, ACK0, RDATA0}, {2'b01, 8'h66});
    REQ0 = 0;
    tick(); tick();

    // REQ0 dropped during ISSUE: access still completes, no second access.
    REQ0 = 1; ADDR0 = 4'h2; WR0 = 0;
    wait_cs("early_cs", 6);
    REQ0 = 0;
    tick(); tick();
    chk("early_ack", {ACK1, ACK0}, 2'b01);
    chk("early_rdata", RDATA0, 8'h22);
    cnt = 0;
    for (int t = 0; t < 8; t++) begin tick(); if (ACK0 || ACK1 || PORT_CS) cnt++; end
    chk("early_no_second", cnt, 0);

`ifdef GPO_ARB_LOCK_EN
    // Locked access blocks REQ1 until LOCK_TMO idle cycles pass.
    do_reset();
    LOCK0 = 1; REQ0 = 1; ADDR0 = 4'h4; WR0 = 1; WDATA0 = 8'h44;
    tick();
    chk("lock_grant0", PORT_CS, 1);
    REQ1 = 1; ADDR1 = 4'h4; WR1 = 0;
    tick(); tick();
    chk("lock_ack0", {ACK1, ACK0}, 2'b01);
    REQ0 = 0;
    cnt = 0;
    for (int t = 0; t < 5; t++) begin tick(); if (PORT_CS) cnt++; end
    chk("lock_blocked", cnt, 0);
    tick();
    chk("lock_release_grant", {PORT_CS, RD_WR, OFFSET_SEL}, {2'b11, 16'h0010});
    tick(); tick();
    chk("lock_ack1", {ACK1, ACK0, RDATA1}, {2'b10, 8'h44});
    REQ1 = 0; LOCK0 = 0;
    tick(); tick();
`endif

    // Random run against the transaction model.
    do_reset();
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'(i * 17);
    exp_rd[0] = 0; exp_rd[1] = 0;
    m_ptr = 1'b0; g_edge = -100; g_who = 0; g_addr = 0; g_wr = 0; g_wd = 0; g_rd = 0;
    pend0 = 0; pend1 = 0;
    for (int n = 0; n < 1500; n++) begin
      tick();
      if (cyc >= g_edge + 4 && (REQ0 || REQ1)) begin
        g_who  = (REQ0 && REQ1) ? m_ptr : REQ1;
        m_ptr  = ~g_who;
        g_edge = cyc;
        g_addr = g_who ? ADDR1 : ADDR0;
        g_wr   = g_who ? WR1 : WR0;
        g_wd   = g_who ? WDATA1 : WDATA0;
        g_rd   = g_wr ? g_wd : exp_mem[g_addr];
        if (g_wr) exp_mem[g_addr] = g_wd;
      end
      e_cs   = (cyc == g_edge);
      e_ack0 = (cyc == g_edge + 2) && !g_who;
      e_ack1 = (cyc == g_edge + 2) && g_who;
      if (e_ack0 || e_ack1) exp_rd[g_who] = g_rd;
      chk("rnd_cs", PORT_CS, e_cs);
      chk("rnd_offset", OFFSET_SEL, e_cs ? (one16 << g_addr) : 16'h0);
      chk("rnd_rd_wr", RD_WR, e_cs & ~g_wr);
      chk("rnd_din", DIN, e_cs ? g_wd : 8'h00);
      chk("rnd_ack", {ACK1, ACK0}, {e_ack1, e_ack0});
      chk("rnd_busy", BUSY, (cyc >= g_edge) && (cyc <= g_edge + 2));
      chk("rnd_rdata", {RDATA1, RDATA0}, {exp_rd[1], exp_rd[0]});

      if (e_ack0) begin pend0 = 0; REQ0 = 0; end
      if (!pend0 && $urandom_range(2, 0) == 0) begin
        pend0 = 1; REQ0 = 1; ADDR0 = 4'($urandom); WR0 = 1'($urandom); WDATA0 = 8'($urandom);
      end else if (pend0 && e_cs && !g_who && $urandom_range(7, 0) == 0) begin
        REQ0 = 0;
      end
      if (e_ack1) begin pend1 = 0; REQ1 = 0; end
      if (!pend1 && $urandom_range(2, 0) == 0) begin
        pend1 = 1; REQ1 = 1; ADDR1 = 4'($urandom); WR1 = 1'($urandom); WDATA1 = 8'($urandom);
      end else if (pend1 && e_cs && g_who && $urandom_range(7, 0) == 0) begin
        REQ1 = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
